booth_r4_mult: RTL and testbench
================================

Name: booth_r4_mult

Overview:
- Self-contained radix-4 (modified) Booth multiplier with an integrated controller and Request/Done handshake. It replaces the externally sequenced add/sub/shift datapath.
- Parametrised operand width, plus a per-request signed/unsigned mode.
- Fixed latency independent of operand values.
- Sits under the arithmetic controller as a multi-cycle functional unit.

Parameters:
- N_LEN, 8, operand width in bits; must be even and >= 4.
- ITER, N_LEN/2+1 (derived, localparam), radix-4 iterations per multiply.

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- Request  input  1  start/hold handshake from the controller.
- signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned. Sampled with operands.
- op1  input  N_LEN  multiplicand.
- op2  input  N_LEN  multiplier.
- Busy  output  1  high while a multiply is in progress (CALC state).
- Done  output  1  result valid.
- Result  output  2*N_LEN  product, held stable between operations.
- Q_out  output  2  state code: IDLE=00, CALC=01, DONE=10.

Behaviour:
- Reset: clock and reset are one clock, asynchronous active-low reset (nReset).
  - nReset low at any time, including mid-operation: state to IDLE, Busy=0, Done=0, Result=0, Q_out=00, iteration counter=0, internal registers cleared.
  - The aborted operation is lost. No output glitch after release.
- Internal width:
  - W = N_LEN+2.
  - op1/op2 are sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to W bits.
  - Product register is {A[W:0], Q[W-1:0], q_m1}, where A is W+1 bits so it can hold ±2M.
- IDLE:
  - Rising edge with Request=1 loads M=ext(op1), Q=ext(op2), A=0, q_m1=0, counter=0, then goes to CALC.
  - Operands and signed_mode are ignored at all other times.
- CALC: one iteration per clock.
  - Encode {Q[1],Q[0],q_m1}: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Add or subtract into A with W+1-bit wraparound.
  - Then arithmetic shift right by 2 of the whole {A,Q,q_m1}.
  - Counter increments each iteration.
  - After the ITER-th iteration, go to DONE and register Result = Q[2*N_LEN-1:0] of the final {A,Q} concatenation (the low 2*N_LEN bits of the product).
  - Request is ignored during CALC; dropping it does not abort.
- Latency:
  - Request sampled at edge k.
  - Done=1 and Result valid after edge k+ITER+1 (k+6 for N_LEN=8).
  - Busy=1 for exactly ITER cycles.
- DONE:
  - Done=1, Busy=0.
  - Stays in DONE while Request=1 (four-phase handshake).
  - Returns to IDLE on the first edge with Request=0. If Request is already low, Done is high for exactly one cycle.
  - A new Request is accepted only from IDLE, so Request must be seen low at least once between operations.
- Result:
  - Updates only on the CALC->DONE transition.
  - Holds through DONE, IDLE and the whole next CALC.
- Width rules:
  - Signed: the full 2*N_LEN-bit product is exact; -2^(N_LEN-1) squared gives 2^(2N_LEN-2) with no overflow.
  - Unsigned: the full product is exact up to (2^N_LEN-1)^2.
- Q_out reflects the registered state only, never a combinational next-state value.

Test Plan:
- N_LEN=8, signed, op1=15, op2=23, Request held high -> Busy high for 5 cycles; Done rises 6 edges after the start edge; Result=16'h0159; Done stays high until Request drops, then Q_out=00.
- Signed corner cases: -128 x -128 -> 16'h4000; -1 x 1 -> 16'hFFFF; -128 x 127 -> 16'hC080; 0 x -77 -> 16'h0000.
- Unsigned mode: 255 x 255 -> 16'hFE01; 200 x 3 -> 16'h0258. Same bit patterns in signed mode: 8'hFF x 8'hFF -> 16'h0001.
- Handshake:
  - Request pulsed one cycle -> Done high exactly one cycle.
  - op1/op2 changed during CALC -> Result unaffected.
  - Request held high after DONE -> no restart until it drops and rises again.
  - Back-to-back operations each give the correct result.
- Assert nReset on the 3rd CALC cycle -> immediately Busy=0, Done=0, Result=0, Q_out=00. The next request after release computes correctly (15 x 23 = 345).
- N_LEN=16: random signed/unsigned pairs (>=1000) checked against a behavioural product; latency 9 iterations plus 1 load cycle.

Source files
------------

// File: rtl/booth_r4_mult.sv
// rtl/booth_r4_mult.sv - radix-4 Booth multiplier with Request/Done handshake
// Fixed latency: ITER iterations plus one result-registration cycle.
module booth_r4_mult #(
    parameter int N_LEN = 8
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Request,
    input  logic                 signed_mode,
    input  logic [N_LEN-1:0]     op1,
    input  logic [N_LEN-1:0]     op2,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*N_LEN-1:0]   Result,
    output logic [1:0]           Q_out
);
    localparam int ITER = N_LEN / 2 + 1;
    localparam int W    = N_LEN + 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [W:0]           a_q, a_d;
    logic [W-1:0]         q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [W-1:0]         m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*N_LEN-1:0]   result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [W:0]           m_w;
    logic [W:0]           pp;
    logic [W:0]           a_sum;
    logic [2*W+1:0]       shifted;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // Booth digit from {Q[1],Q[0],q_m1}; A is one bit wider than M to hold +-2M
        m_w = {m_q[W-1], m_q};
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: pp = m_w;
            3'b011:         pp = m_w << 1;
            3'b100:         pp = -(m_w << 1);
            3'b101, 3'b110: pp = -m_w;
            default:        pp = '0;
        endcase
        a_sum   = a_q + pp;
        shifted = $signed({a_sum, q_q, qm1_q}) >>> 2;

        case (state_q)
            S_IDLE: begin
                if (Request) begin
                    m_d     = signed_mode ? {{2{op1[N_LEN-1]}}, op1} : {2'b00, op1};
                    q_d     = signed_mode ? {{2{op2[N_LEN-1]}}, op2} : {2'b00, op2};
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q < CW'(ITER)) begin
                    a_d   = shifted[2*W+1:W+1];
                    q_d   = shifted[W:1];
                    qm1_d = shifted[0];
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    result_d = {a_q[N_LEN-3:0], q_q};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (!Request) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) && (cnt_d < CW'(ITER));
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;
    assign Q_out  = state_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// tb/tb_booth_r4_mult.sv - directed and random checks of booth_r4_mult
module tb_booth_r4_mult;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic [1:0]  qo8;
    logic        req16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] res16;
    logic [1:0]  qo16;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [15:0] last_exp8 = 16'h0;

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [10];

    booth_r4_mult #(.N_LEN(8)) dut8 (
        .Clock(clk), .nReset(rst_n), .Request(req8), .signed_mode(sm8),
        .op1(a8), .op2(b8), .Busy(busy8), .Done(done8), .Result(res8), .Q_out(qo8)
    );

    booth_r4_mult #(.N_LEN(16)) dut16 (
        .Clock(clk), .nReset(rst_n), .Request(req16), .signed_mode(sm16),
        .op1(a16), .op2(b16), .Busy(busy16), .Done(done16), .Result(res16), .Q_out(qo16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input logic hold, input string name);
        int cyc, busy_n;
        logic seen;
        @(negedge clk);
        req8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        cyc = 0; busy_n = 0; seen = 1'b0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (!hold) req8 = 1'b0;
                check({name, " result_held_in_calc"}, {16'h0, res8}, {16'h0, last_exp8});
            end
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            if (busy8) busy_n++;
            if (done8) begin seen = 1'b1; break; end
        end
        check({name, " done_seen"}, {31'h0, seen}, 32'h1);
        check({name, " latency"}, cyc - 1, 6);
        check({name, " busy_cycles"}, busy_n, 5);
        check({name, " result"}, {16'h0, res8}, {16'h0, exp});
        last_exp8 = exp;
        if (hold) begin
            repeat (4) begin
                @(negedge clk);
                check({name, " hold_in_done"}, {28'h0, busy8, done8, qo8}, {28'h0, 1'b0, 1'b1, 2'b10});
            end
            req8 = 1'b0;
        end
        @(negedge clk);
        check({name, " back_to_idle"}, {29'h0, done8, qo8}, 32'h0);
        check({name, " result_held_idle"}, {16'h0, res8}, {16'h0, exp});
    endtask

    task automatic op16(input logic sm, input logic [15:0] a, input logic [15:0] b);
        int cyc, busy_n;
        logic [31:0] exp;
        if (sm) exp = 32'($signed(a)) * 32'($signed(b));
        else    exp = {16'h0, a} * {16'h0, b};
        @(negedge clk);
        req16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        cyc = 0; busy_n = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            req16 = 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom);
            if (busy16) busy_n++;
            if (done16) break;
        end
        check("n16 latency_busy", {cyc - 1, busy_n}, {32'd10, 32'd9});
        check("n16 result", res16, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        req16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        vecs[0] = '{1'b1, 8'd15,  8'd23,  16'h0159};
        vecs[1] = '{1'b1, 8'h80,  8'h80,  16'h4000};
        vecs[2] = '{1'b1, 8'hFF,  8'h01,  16'hFFFF};
        vecs[3] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        vecs[4] = '{1'b1, 8'h00,  8'hB3,  16'h0000};
        vecs[5] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
        vecs[6] = '{1'b0, 8'd200, 8'd3,   16'h0258};
        vecs[7] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        vecs[8] = '{1'b0, 8'h80,  8'h80,  16'h4000};
        vecs[9] = '{1'b0, 8'hFF,  8'h01,  16'h00FF};

        repeat (3) @(negedge clk);
        check("reset n8", {11'h0, busy8, done8, qo8, res8}, 32'h0);
        check("reset n16", {28'h0, busy16, done16, qo16}, 32'h0);
        check("reset n16 result", res16, 32'h0);
        rst_n = 1'b1;

        op8(1'b1, 8'd15, 8'd23, 16'h0159, 1'b1, "held_15x23");
        for (int i = 0; i < 10; i++)
            op8(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        op8(1'b1, 8'd7, 8'hFD, 16'hFFEB, 1'b1, "held_7xm3");

        // abort on the third CALC cycle, then a clean restart
        @(negedge clk);
        req8 = 1'b1; sm8 = 1'b1; a8 = 8'd100; b8 = 8'd99;
        repeat (3) begin
            @(negedge clk);
            req8 = 1'b0;
        end
        check("pre_abort busy", {31'h0, busy8}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort outputs", {11'h0, busy8, done8, qo8, res8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp8 = 16'h0;
        op8(1'b1, 8'd15, 8'd23, 16'h0159, 1'b0, "after_abort");

        op16(1'b1, 16'h8000, 16'h8000);
        op16(1'b0, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 1000; i++)
            op16(1'($urandom), 16'($urandom), 16'($urandom));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
